mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin scheduler that shares one 16-bit shift-add `Multiplier` instance between `NREQ` independent requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `x`, `y` and `start` inputs. Because the multiplier has no done flag, completion is timed with a fixed-latency counter. Each 32-bit product is returned to the owning requester over a per-requester response handshake. Zero-operand requests bypass the multiplier.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `MULT_LAT`, 40: cycles from the `m_start` pulse until `m_mult` is final and stable (≥1).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NREQ  requester i has an operand pair pending.
- `req_x`  in  16*NREQ  multiplicand, requester i at bits [16i+15:16i].
- `req_y`  in  16*NREQ  multiplier, same packing.
- `req_ready`  out  NREQ  one-hot acceptance strobe.
- `rsp_valid`  out  NREQ  one-hot; product available for requester i.
- `rsp_ready`  in  NREQ  requester i consumes the product.
- `rsp_mult`  out  32  product; valid while any `rsp_valid` bit is high.
- `m_x`, `m_y`  out  16  operands to the shared multiplier.
- `m_start`  out  1  start pulse to the shared multiplier.
- `m_mult`  in  32  product from the shared multiplier.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction is in flight at a time.
- **IDLE:**
  - The winner is the first requester with `req_valid` high, searching from `last+1` upward modulo NREQ.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On that cycle the block latches operands, owner id `own`, and sets `last<=winner`.
  - If either latched operand is 0: result register <= 0 and the next state is RESP. ISSUE and WAIT are skipped and `m_start` never pulses.
  - Otherwise the next state is ISSUE.
- **ISSUE:** `m_start=1` for exactly this cycle and `m_x`/`m_y` are driven from the latched operands. The counter is loaded with `MULT_LAT`. Next state is WAIT.
- **WAIT:**
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, `m_mult` is captured into the result register and the next state is RESP.
  - WAIT therefore lasts exactly `MULT_LAT` cycles.
- **RESP:**
  - `rsp_valid[own]=1` and `rsp_mult` = result register.
  - Both are held stable until `rsp_ready[own]` is high in the same cycle; the next state is then IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- **Multiplier inputs:**
  - `m_x`/`m_y` are registered and stay constant from ISSUE through the end of WAIT.
  - They keep the last issued operands afterwards and change only in ISSUE.
- **Products:** the full 32-bit product is returned unmodified; no truncation or saturation.
- **Fairness:** a requester that was just served has lowest priority next arbitration. With all NREQ requesting, grants rotate 0,1,…,NREQ-1,0.
- **Request-side rules:**
  - Dropping `req_valid` before acceptance is legal; the requester is simply not considered.
  - Operands are sampled only on the acceptance cycle.
- **Reset** (any cycle, including mid-WAIT or RESP):
  - state=IDLE, `last=NREQ-1` so requester 0 wins first.
  - Counter=0, result=0, `m_x=m_y=0`, `m_start=0`.
  - `req_ready=0`, `rsp_valid=0`, `rsp_mult=0`, `busy=0`.
  - An in-flight product is discarded with no response. The shared multiplier is not reset by this block.

## Timing
- Acceptance at cycle T (`req_ready` high), nonzero operands:
  - `m_start` is high at T+1.
  - WAIT runs T+2..T+1+MULT_LAT.
  - `rsp_valid` is first high at T+2+MULT_LAT.
- Acceptance at T with a zero operand: `rsp_valid` is high at T+1.
- `rsp_ready` held high: RESP lasts one cycle, giving a minimum issue-to-issue spacing of MULT_LAT+3 cycles.
- The earliest next acceptance is the cycle after the RESP handshake; there is no acceptance in the same cycle as a response handshake.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Test plan
- **Reset:** hold `rst` 3 cycles → all outputs 0 and `busy=0`. Then req0 x=3,y=5 → `req_ready[0]` at T, `m_start` pulse only at T+1, `rsp_mult=15` with `rsp_valid[0]` at T+2+MULT_LAT.
- **Full-range product:** x=16'hFFFF, y=16'hFFFF → `rsp_mult=32'hFFFE0001`. `m_x`/`m_y` stay constant through WAIT.
- **Round-robin:** all 4 requesters hold `req_valid` with distinct operands → grant order 0,1,2,3,0. Each `rsp_valid` goes only to its owner with the correct product.
- **Zero bypass:** req2 x=0,y=1234 → `m_start` stays 0 and `rsp_valid[2]`, `rsp_mult=0` at T+1.
- **Backpressure:** hold `rsp_ready[1]=0` for 10 cycles in RESP while req3 is valid → `rsp_mult` stable, `busy=1`, `req_ready[3]=0`. Release → req3 accepted the cycle after the handshake.
- **Mid-operation reset:** assert `rst` in cycle 5 of WAIT → next cycle IDLE, no `rsp_valid`, `last` reset so requester 0 wins the next arbitration.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Bundle of requester handshakes and shared-multiplier connections for mult_arbiter.
// The slave side is the arbiter; the master side is the surrounding environment
// (requesters plus the shared multiplier).
interface mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_x;
  logic [16*NREQ-1:0] req_y;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_mult;
  logic [15:0]        m_x;
  logic [15:0]        m_y;
  logic               m_start;
  logic [31:0]        m_mult;
  logic               busy;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, m_mult,
    output req_ready, rsp_valid, rsp_mult, m_x, m_y, m_start, busy
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready, m_mult,
    input  req_ready, rsp_valid, rsp_mult, m_x, m_y, m_start, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one fixed-latency 16x16 multiplier between NREQ
// requesters. One transaction in flight; zero operands bypass the multiplier.
module mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 40
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MULT_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  own;
  logic [CW-1:0]   cnt;
  logic [31:0]     result;
  logic [15:0]     m_x_r;
  logic [15:0]     m_y_r;
  logic            m_start_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic            busy_r;

  logic            found;
  logic [IDW-1:0]  winner;
  logic [15:0]     x_sel;
  logic [15:0]     y_sel;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req_valid[IDW'((int'(last) + k) % NREQ)]) begin
        found  = 1'b1;
        winner = IDW'((int'(last) + k) % NREQ);
      end
    end
  end

  // Acceptance strobe is combinational so the winner sees ready in its request cycle.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state == IDLE && found) bus.req_ready[winner] = 1'b1;
  end

  assign x_sel = bus.req_x[16*winner +: 16];
  assign y_sel = bus.req_y[16*winner +: 16];

  // Transaction FSM: arbitrate, pulse the multiplier, time its latency, return the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= IDW'(NREQ - 1);
      own         <= '0;
      cnt         <= '0;
      result      <= '0;
      m_x_r       <= '0;
      m_y_r       <= '0;
      m_start_r   <= 1'b0;
      rsp_valid_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            own    <= winner;
            last   <= winner;
            busy_r <= 1'b1;
            if (x_sel == 16'd0 || y_sel == 16'd0) begin
              result      <= '0;
              rsp_valid_r <= NREQ'(1) << winner;
              state       <= RESP;
            end else begin
              m_x_r     <= x_sel;
              m_y_r     <= y_sel;
              m_start_r <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          m_start_r <= 1'b0;
          cnt       <= CW'(MULT_LAT);
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result      <= bus.m_mult;
            rsp_valid_r <= NREQ'(1) << own;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[own]) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_x       = m_x_r;
  assign bus.m_y       = m_y_r;
  assign bus.m_start   = m_start_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_mult  = result;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios followed by randomized transactions,
// checked against a transaction-level reference model and a behavioural multiplier.
module tb_mult_arbiter;

  localparam int NREQ     = 4;
  localparam int MULT_LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_arbiter_if #(.NREQ(NREQ)) bus ();

  mult_arbiter #(.NREQ(NREQ), .MULT_LAT(MULT_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared multiplier model: output is corrupted until MULT_LAT cycles after start.
  int          mc    = 0;
  logic [31:0] mprod = '0;
  always @(posedge clk) begin
    if (bus.m_start) begin
      mprod <= 32'(bus.m_x) * 32'(bus.m_y);
      mc    <= MULT_LAT - 1;
    end else if (mc > 0) begin
      mc <= mc - 1;
    end
  end
  assign bus.m_mult = (mc != 0) ? (mprod ^ 32'hA5A5_5A5A) : mprod;

  int n_total = 0;
  int n_pass  = 0;
  int mlast   = NREQ - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: first requesting index after the last served one.
  function automatic int pick(input logic [NREQ-1:0] mask, input int lst);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(lst + k) % NREQ]) return (lst + k) % NREQ;
    return 0;
  endfunction

  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [16*NREQ-1:0] xs,
                         input logic [16*NREQ-1:0] ys, input int stall,
                         input logic [NREQ-1:0] hold, input int exp_w);
    int              w;
    int              lat;
    logic            nz;
    logic            got;
    logic [15:0]     xa;
    logic [15:0]     ya;
    logic [31:0]     exp_p;
    logic [NREQ-1:0] wmask;
    w     = (exp_w >= 0) ? exp_w : pick(mask, mlast);
    wmask = NREQ'(1) << w;
    bus.req_x     = xs;
    bus.req_y     = ys;
    bus.req_valid = mask;
    bus.rsp_ready = '0;
    #1;
    check("req_ready_grant", bus.req_ready, wmask);
    xa    = xs[16*w +: 16];
    ya    = ys[16*w +: 16];
    exp_p = 32'(xa) * 32'(ya);
    nz    = (xa != 16'd0) && (ya != 16'd0);
    step();
    bus.req_valid = hold;
    mlast = w;
    #1;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= MULT_LAT + 4) begin
      check("m_start", bus.m_start, 32'(lat == 1 && nz));
      check("busy_inflight", bus.busy, 1);
      if (nz) begin
        check("m_x_hold", bus.m_x, xa);
        check("m_y_hold", bus.m_y, ya);
      end
      if (hold != '0) check("req_ready_busy", bus.req_ready, 0);
      if (bus.rsp_valid != '0) got = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    check("rsp_latency", lat, nz ? MULT_LAT + 2 : 1);
    check("rsp_valid_owner", bus.rsp_valid, wmask);
    check("rsp_mult", bus.rsp_mult, exp_p);
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = NREQ'($urandom) & ~wmask;
      #1;
      check("stall_rsp_valid", bus.rsp_valid, wmask);
      check("stall_rsp_mult", bus.rsp_mult, exp_p);
      check("stall_busy", bus.busy, 1);
      check("stall_req_ready", bus.req_ready, 0);
      step();
    end
    bus.rsp_ready = wmask | NREQ'($urandom);
    #1;
    check("hs_req_ready", bus.req_ready, 0);
    step();
    bus.rsp_ready = '0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_busy", bus.busy, 0);
  endtask

  task automatic apply_reset(input int cycles, input logic [NREQ-1:0] vld);
    rst = 1'b1;
    bus.req_valid = vld;
    bus.rsp_ready = '0;
    repeat (cycles) step();
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_mult", bus.rsp_mult, 0);
    check("rst_m_start", bus.m_start, 0);
    check("rst_m_x", bus.m_x, 0);
    check("rst_m_y", bus.m_y, 0);
    check("rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    bus.req_valid = '0;
    mlast = NREQ - 1;
  endtask

  initial begin
    logic [NREQ-1:0]    rmask;
    logic [16*NREQ-1:0] rx;
    logic [16*NREQ-1:0] ry;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = '0;

    // Reset with every requester pending, then a simple product
    apply_reset(3, 4'b1111);
    run_txn(4'b0001, {48'd0, 16'd3}, {48'd0, 16'd5}, 0, '0, 0);

    // Full-range operands
    run_txn(4'b0001, {48'd0, 16'hFFFF}, {48'd0, 16'hFFFF}, 1, '0, 0);

    // Round-robin from a fresh reset with all requesters active
    apply_reset(1, '0);
    rx = {16'd7, 16'd300, 16'd1000, 16'd65535};
    ry = {16'd9, 16'd123, 16'd4242, 16'd2};
    run_txn(4'b1111, rx, ry, 0, '0, 0);
    run_txn(4'b1111, rx, ry, 0, '0, 1);
    run_txn(4'b1111, rx, ry, 0, '0, 2);
    run_txn(4'b1111, rx, ry, 0, '0, 3);
    run_txn(4'b1111, rx, ry, 0, '0, 0);

    // Zero bypass on requester 2
    run_txn(4'b0100, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd1234, 16'd0, 16'd0}, 0, '0, 2);

    // Backpressure on requester 1 with requester 3 waiting, then requester 3 served
    run_txn(4'b0010, {16'd0, 16'd0, 16'd77, 16'd0}, {16'd0, 16'd0, 16'd88, 16'd0}, 10, 4'b1000, 1);
    run_txn(4'b1000, {16'd501, 48'd0}, {16'd499, 48'd0}, 0, '0, 3);

    // Reset in the fifth WAIT cycle discards the transaction
    bus.req_x     = {16'd0, 16'd9, 32'd0};
    bus.req_y     = {16'd0, 16'd11, 32'd0};
    bus.req_valid = 4'b0100;
    #1;
    check("mid_grant", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    repeat (5) step();
    check("mid_busy_wait", bus.busy, 1);
    check("mid_rsp_wait", bus.rsp_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mlast = NREQ - 1;
    check("mid_busy_after", bus.busy, 0);
    check("mid_m_start_after", bus.m_start, 0);
    check("mid_m_x_after", bus.m_x, 0);
    repeat (MULT_LAT + 3) begin
      check("mid_no_rsp", bus.rsp_valid, 0);
      step();
    end
    run_txn(4'b1111, rx, ry, 0, '0, 0);

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      rmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        rx[16*i +: 16] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
        ry[16*i +: 16] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      end
      run_txn(rmask, rx, ry, $urandom_range(0, 3), '0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
